// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-flow controller for a 2K x 14 program ROM. Owns the program
//   counter, fetches one word per cycle into the instruction register and
//   applies goto / call / return / skip / computed-PCL updates requested by
//   the decoder for the instruction currently held in IR. Keeps an 8-level
//   circular return stack with saturating occupancy count.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rom_addr_out      ROM address (the PC register)
//   rom_data_in       ROM word at rom_addr_out, same cycle
//   ir_out, ir_valid  instruction register and its valid flag (0 = bubble)
//   pc_out            current PC for debug / PCL readback
//   stall             freeze all state, control inputs ignored
//   goto_en, call_en, ret_en, skip_en, target_in   decoder controls
//   pcl_wr_en, pcl_data_in, pclath_in              computed goto
//   stack_depth       occupied return-stack entries, 0..8
//
// Optional feature, macro PC_STACK_FLAGS_EN:
//   adds stk_flag_clr (in), stk_ovf and stk_unf (out), sticky flags for
//   push at full depth and pop at empty depth.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 11,
    parameter int                DATA_W       = 14,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 11'h000,
    parameter logic [DATA_W-1:0] NOP_WORD     = 14'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              goto_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              skip_en,
    input  logic [ADDR_W-1:0] target_in,
    input  logic              pcl_wr_en,
    input  logic [7:0]        pcl_data_in,
    input  logic [4:0]        pclath_in,
    output logic [3:0]        stack_depth
`ifdef PC_STACK_FLAGS_EN
    ,
    input  logic              stk_flag_clr,
    output logic              stk_ovf,
    output logic              stk_unf
`endif
);

    localparam int         SP_W      = $clog2(STACK_DEPTH);
    localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_p0, pc_d;
    logic [DATA_W-1:0] ir_p1, ir_d;
    logic              vld_p1, vld_d;
    logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
    logic [3:0]        depth_q, depth_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              push, pop;
    logic [ADDR_W-1:0] pop_data;

    // Pop reads registered stack content, so call followed directly by
    // return needs no bypass path.
    assign sp_m1    = sp_q - 1'b1;
    assign pop_data = stack_q[sp_m1];

    always_comb begin
        pc_d  = pc_p0;
        ir_d  = ir_p1;
        vld_d = vld_p1;
        push  = 1'b0;
        pop   = 1'b0;
        if (!stall) begin
            // Decoder priority: ret > call > goto > pcl write > skip.
            if (ret_en) begin
                pop   = 1'b1;
                pc_d  = pop_data;
                ir_d  = NOP_WORD;
                vld_d = 1'b0;
            end else if (call_en) begin
                push  = 1'b1;
                pc_d  = target_in;
                ir_d  = NOP_WORD;
                vld_d = 1'b0;
            end else if (goto_en) begin
                pc_d  = target_in;
                ir_d  = NOP_WORD;
                vld_d = 1'b0;
            end else if (pcl_wr_en) begin
                pc_d  = ADDR_W'({pclath_in[2:0], pcl_data_in});
                ir_d  = NOP_WORD;
                vld_d = 1'b0;
            end else if (skip_en) begin
                pc_d  = pc_p0 + 1'b1;
                ir_d  = NOP_WORD;
                vld_d = 1'b0;
            end else begin
                pc_d  = pc_p0 + 1'b1;
                ir_d  = rom_data_in;
                vld_d = 1'b1;
            end
        end
    end

    // Pointer always moves; only the occupancy count saturates at 0 and 8.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        if (push) begin
            sp_d = sp_q + 1'b1;
            if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
        end else if (pop) begin
            sp_d = sp_m1;
            if (depth_q != 4'd0) depth_d = depth_q - 1'b1;
        end
    end

    // Fetch (p0) -> execute (p1) boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0   <= RESET_VECTOR;
            ir_p1   <= NOP_WORD;
            vld_p1  <= 1'b0;
            sp_q    <= '0;
            depth_q <= 4'd0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_p0   <= pc_d;
            ir_p1   <= ir_d;
            vld_p1  <= vld_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            // Return address is the current PC, i.e. the call's address + 1.
            if (push) stack_q[sp_q] <= pc_p0;
        end
    end

    assign rom_addr_out = pc_p0;
    assign pc_out       = pc_p0;
    assign ir_out       = ir_p1;
    assign ir_valid     = vld_p1;
    assign stack_depth  = depth_q;

`ifdef PC_STACK_FLAGS_EN
    logic ovf_q, unf_q;

    // A set in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~stk_flag_clr) | (push & (depth_q == DEPTH_MAX));
            unf_q <= (unf_q & ~stk_flag_clr) | (pop & (depth_q == 4'd0));
        end
    end

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, goto_en, call_en, ret_en, skip_en, pcl_wr_en, stk_flag_clr;
    logic [10:0] target_in;
    logic [7:0]  pcl_data_in;
    logic [4:0]  pclath_in;
    logic [10:0] rom_addr_out, pc_out;
    logic [13:0] rom_data_in, ir_out;
    logic        ir_valid;
    logic [3:0]  stack_depth;
    logic        stk_ovf, stk_unf;

    logic [13:0] rom [2048];
    assign rom_data_in = rom[rom_addr_out];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr_out(rom_addr_out),
        .rom_data_in (rom_data_in),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .pc_out      (pc_out),
        .stall       (stall),
        .goto_en     (goto_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .skip_en     (skip_en),
        .target_in   (target_in),
        .pcl_wr_en   (pcl_wr_en),
        .pcl_data_in (pcl_data_in),
        .pclath_in   (pclath_in),
        .stack_depth (stack_depth)
`ifdef PC_STACK_FLAGS_EN
        ,
        .stk_flag_clr(stk_flag_clr),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf)
`endif
    );

`ifndef PC_STACK_FLAGS_EN
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

    // Behavioural model: program counter, IR, and a ring of 8 return slots.
    logic [10:0] m_pc;
    logic [13:0] m_ir;
    logic        m_vld;
    int          m_sp;
    int          m_depth;
    logic [10:0] m_stk [8];
    logic        m_ovf, m_unf;

    task automatic idle();
        rst = 0; stall = 0; goto_en = 0; call_en = 0; ret_en = 0; skip_en = 0;
        pcl_wr_en = 0; stk_flag_clr = 0; target_in = '0; pcl_data_in = '0; pclath_in = '0;
    endtask

    // Advance the model by one clock with the current inputs, then clock the DUT.
    task automatic tick();
        if (rst) begin
            m_pc = 11'h000; m_ir = 14'h0000; m_vld = 0; m_sp = 0; m_depth = 0;
            for (int i = 0; i < 8; i++) m_stk[i] = '0;
            m_ovf = 0; m_unf = 0;
        end else begin
            if (stk_flag_clr) begin m_ovf = 0; m_unf = 0; end
            if (!stall) begin
                if (ret_en) begin
                    m_sp = (m_sp + 7) % 8;
                    if (m_depth == 0) m_unf = 1; else m_depth--;
                    m_pc = m_stk[m_sp]; m_ir = 0; m_vld = 0;
                end else if (call_en) begin
                    m_stk[m_sp] = m_pc;
                    m_sp = (m_sp + 1) % 8;
                    if (m_depth == 8) m_ovf = 1; else m_depth++;
                    m_pc = target_in; m_ir = 0; m_vld = 0;
                end else if (goto_en) begin
                    m_pc = target_in; m_ir = 0; m_vld = 0;
                end else if (pcl_wr_en) begin
                    m_pc = 11'((int'(pclath_in) % 8) * 256 + int'(pcl_data_in));
                    m_ir = 0; m_vld = 0;
                end else if (skip_en) begin
                    m_pc = 11'((int'(m_pc) + 1) % 2048); m_ir = 0; m_vld = 0;
                end else begin
                    m_ir = rom[m_pc]; m_vld = 1;
                    m_pc = 11'((int'(m_pc) + 1) % 2048);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; stall = 1; goto_en = 1; target_in = 11'h555;
        tick();
        idle();
        checks++; if (pc_out !== 11'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", pc_out); end
        checks++; if (ir_out !== 14'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", ir_out); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", ir_valid); end
        checks++; if (stack_depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", stack_depth); end
    endtask

    task automatic test_free_run();
        int exp_addr [5] = '{0, 1, 2, 3, 4};
        int exp_ir   [5] = '{0, 0, 1, 2, 3};
        int exp_vld  [5] = '{0, 1, 1, 1, 1};
        for (int i = 0; i < 2048; i++) rom[i] = 14'(i);
        idle(); rst = 1; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++; if (rom_addr_out !== 11'(exp_addr[i])) begin failures++; $display("FAIL free_addr[%0d] got=%h exp=%h", i, rom_addr_out, exp_addr[i]); end
            checks++; if (ir_out !== 14'(exp_ir[i])) begin failures++; $display("FAIL free_ir[%0d] got=%h exp=%h", i, ir_out, exp_ir[i]); end
            checks++; if (ir_valid !== 1'(exp_vld[i])) begin failures++; $display("FAIL free_vld[%0d] got=%b exp=%0d", i, ir_valid, exp_vld[i]); end
        end
    endtask

    task automatic test_goto();
        idle(); tick();
        checks++; if (pc_out !== 11'h005) begin failures++; $display("FAIL goto_pre_pc got=%h exp=005", pc_out); end
        goto_en = 1; target_in = 11'h123; tick(); idle();
        checks++; if (pc_out !== 11'h123) begin failures++; $display("FAIL goto_pc got=%h exp=123", pc_out); end
        checks++; if (ir_valid !== 1'b0 || ir_out !== 14'h0000) begin failures++; $display("FAIL goto_bubble got=%b/%h exp=0/0000", ir_valid, ir_out); end
        tick();
        checks++; if (ir_out !== rom[11'h123] || ir_valid !== 1'b1) begin failures++; $display("FAIL goto_ir got=%h/%b exp=%h/1", ir_out, ir_valid, rom[11'h123]); end
    endtask

    task automatic test_call_ret();
        idle(); goto_en = 1; target_in = 11'h011; tick(); idle();
        call_en = 1; target_in = 11'h200; tick(); idle();
        checks++; if (stack_depth !== 4'd1) begin failures++; $display("FAIL call_depth got=%0d exp=1", stack_depth); end
        checks++; if (pc_out !== 11'h200 || ir_valid !== 1'b0) begin failures++; $display("FAIL call_pc got=%h/%b exp=200/0", pc_out, ir_valid); end
        tick(); tick();
        ret_en = 1; tick(); idle();
        checks++; if (pc_out !== 11'h011) begin failures++; $display("FAIL ret_pc got=%h exp=011", pc_out); end
        checks++; if (stack_depth !== 4'd0 || ir_valid !== 1'b0) begin failures++; $display("FAIL ret_depth got=%0d/%b exp=0/0", stack_depth, ir_valid); end
        tick();
        checks++; if (ir_out !== rom[11'h011] || ir_valid !== 1'b1) begin failures++; $display("FAIL ret_ir got=%h/%b exp=%h/1", ir_out, ir_valid, rom[11'h011]); end
    endtask

    task automatic test_stack_saturation();
        logic [10:0] tgt [9];
        logic [10:0] pushed [9];
        logic [10:0] exp_ret;
        idle(); goto_en = 1; target_in = 11'h300; tick(); idle();
        for (int k = 0; k < 9; k++) begin
            tgt[k]    = 11'($urandom_range(0, 2047));
            pushed[k] = (k == 0) ? 11'h300 : tgt[k-1];
            call_en = 1; target_in = tgt[k]; tick();
`ifdef PC_STACK_FLAGS_EN
            if (k == 7) begin checks++; if (stk_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", stk_ovf); end end
`endif
        end
        idle();
        checks++; if (stack_depth !== 4'd8) begin failures++; $display("FAIL sat_depth got=%0d exp=8", stack_depth); end
`ifdef PC_STACK_FLAGS_EN
        checks++; if (stk_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", stk_ovf); end
`endif
        for (int j = 0; j < 9; j++) begin
            // Calls 9..2 come back in order; the 9th pop reads the slot call 9 overwrote.
            exp_ret = (j < 8) ? pushed[8-j] : pushed[8];
            ret_en = 1; tick();
            checks++; if (pc_out !== exp_ret) begin failures++; $display("FAIL sat_ret[%0d] got=%h exp=%h", j, pc_out, exp_ret); end
        end
        idle();
        checks++; if (stack_depth !== 4'd0) begin failures++; $display("FAIL unf_depth got=%0d exp=0", stack_depth); end
`ifdef PC_STACK_FLAGS_EN
        checks++; if (stk_unf !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", stk_unf); end
        stk_flag_clr = 1; tick(); idle();
        checks++; if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin failures++; $display("FAIL flag_clr got=%b%b exp=00", stk_ovf, stk_unf); end
`endif
    endtask

    task automatic test_skip_pcl();
        idle(); goto_en = 1; target_in = 11'h03F; tick(); idle();
        tick();
        skip_en = 1; tick(); idle();
        checks++; if (pc_out !== 11'h041) begin failures++; $display("FAIL skip_pc got=%h exp=041", pc_out); end
        checks++; if (ir_out !== 14'h0000 || ir_valid !== 1'b0) begin failures++; $display("FAIL skip_ir got=%h/%b exp=0000/0", ir_out, ir_valid); end
        pcl_wr_en = 1; pcl_data_in = 8'h80; pclath_in = 5'h05; tick(); idle();
        checks++; if (pc_out !== 11'h580 || ir_valid !== 1'b0) begin failures++; $display("FAIL pcl_pc got=%h/%b exp=580/0", pc_out, ir_valid); end
    endtask

    task automatic test_stall_reset();
        logic [10:0] s_pc;
        logic [13:0] s_ir;
        logic        s_vld;
        int          s_depth;
        idle(); call_en = 1; target_in = 11'h2A0; tick(); idle(); tick();
        s_pc = m_pc; s_ir = m_ir; s_vld = m_vld; s_depth = m_depth;
        stall = 1; goto_en = 1; target_in = 11'h7AB;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rom_addr_out !== s_pc || ir_out !== s_ir || ir_valid !== s_vld || stack_depth !== 4'(s_depth))
                begin failures++; $display("FAIL stall_hold[%0d] got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", i, rom_addr_out, ir_out, ir_valid, stack_depth, s_pc, s_ir, s_vld, s_depth); end
        end
        rst = 1; tick(); idle();
        checks++; if (pc_out !== 11'h000 || stack_depth !== 4'd0 || ir_valid !== 1'b0) begin failures++; $display("FAIL stall_rst got=%h/%0d/%b exp=000/0/0", pc_out, stack_depth, ir_valid); end
        tick();
        checks++; if (pc_out !== 11'h001 || ir_valid !== 1'b1) begin failures++; $display("FAIL post_rst got=%h/%b exp=001/1", pc_out, ir_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2048; i++) rom[i] = 14'($urandom);
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            ret_en       = ($urandom_range(0, 5) == 0);
            call_en      = ($urandom_range(0, 4) == 0);
            goto_en      = ($urandom_range(0, 6) == 0);
            pcl_wr_en    = ($urandom_range(0, 6) == 0);
            skip_en      = ($urandom_range(0, 5) == 0);
            stk_flag_clr = ($urandom_range(0, 7) == 0);
            target_in    = 11'($urandom);
            pcl_data_in  = 8'($urandom);
            pclath_in    = 5'($urandom);
            tick();
            checks++; if (pc_out !== m_pc || rom_addr_out !== m_pc || ir_out !== m_ir || ir_valid !== m_vld || stack_depth !== 4'(m_depth))
                begin failures++; $display("FAIL rand[%0d] got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", n, pc_out, ir_out, ir_valid, stack_depth, m_pc, m_ir, m_vld, m_depth); end
`ifdef PC_STACK_FLAGS_EN
            checks++; if (stk_ovf !== m_ovf || stk_unf !== m_unf) begin failures++; $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", n, stk_ovf, stk_unf, m_ovf, m_unf); end
`endif
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        idle();
        test_reset();
        test_free_run();
        test_goto();
        test_call_ret();
        test_stack_saturation();
        test_skip_pcl();
        test_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
